ign_output_stage: RTL and testbench

- Parametrised N-channel ignition output stage between the per-cylinder ignition drivers and the coil output pins.
- Generalises the fixed 4-channel individual/distributor selection to N channels with three routing modes: individual, wasted-spark and distributor.
- Adds per-coil over-dwell protection, a minimum off-time lockout and sticky fault flags readable over the SPI status registers.

---
 rtl/efi_pkg.sv | 17 +
 rtl/ign_coil_guard.sv | 114 +++++++++++
 rtl/ign_output_stage.sv | 97 +++++++++
 tb/tb_ign_output_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/efi_pkg.sv
// Shared definitions for the ignition output stage.
//   MODE_*        : routing mode encodings on the mode input
//   guard_state_e : per-coil guard FSM state encoding
package efi_pkg;

    localparam logic [1:0] MODE_INDIV  = 2'd0;
    localparam logic [1:0] MODE_WASTED = 2'd1;
    localparam logic [1:0] MODE_DIST   = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        LOCKOUT = 2'd2
    } guard_state_e;

endpackage

// File: rtl/ign_coil_guard.sv
// Per-coil guard: dwell limit, minimum off-time and sticky over-dwell flag.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   req            : registered physical request for this coil
//   force_lock     : drop the coil and relock (routing mode changed)
//   max_dwell      : over-dwell limit in cycles, 0 disables the limit
//   min_off        : minimum LOCKOUT length in cycles
//   clear_fault    : clears the sticky fault (a same-cycle set wins)
//   ign            : registered coil drive
//   fault          : sticky over-dwell flag
//   fault_nxt      : next-state value of fault, for the registered OR at top
//
// state   | meaning
// IDLE    | coil off, ready to charge on request
// CHARGE  | coil charging, dwell counter running
// LOCKOUT | coil off, waiting for min_off and a released request
module ign_coil_guard
    import efi_pkg::*;
#(
    parameter int DWELL_W = 20,
    parameter int OFF_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req,
    input  logic               force_lock,
    input  logic [DWELL_W-1:0] max_dwell,
    input  logic [OFF_W-1:0]   min_off,
    input  logic               clear_fault,
    output logic               ign,
    output logic               fault,
    output logic               fault_nxt
);

    localparam int CNT_W = (DWELL_W > OFF_W) ? DWELL_W : OFF_W;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_OFF_MAX = CNT_W'({OFF_W{1'b1}});

    guard_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             release_seen, release_nxt;
    logic [CNT_W-1:0] dwell_lim;
    logic [CNT_W-1:0] off_lim;

    assign dwell_lim = CNT_W'(max_dwell) - CNT_ONE;
    // min_off of 0 or 1 both mean a single LOCKOUT cycle.
    assign off_lim   = (min_off == '0) ? '0 : (CNT_W'(min_off) - CNT_ONE);

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        release_nxt = release_seen | ~req;
        fault_nxt   = fault & ~clear_fault;

        if (force_lock) begin
            state_nxt   = LOCKOUT;
            cnt_nxt     = '0;
            release_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state_nxt = CHARGE;
                        cnt_nxt   = '0;
                    end
                end
                CHARGE: begin
                    cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
                    if (!req) begin
                        state_nxt   = LOCKOUT;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else if ((max_dwell != '0) && (cnt == dwell_lim)) begin
                        state_nxt   = LOCKOUT;
                        cnt_nxt     = '0;
                        release_nxt = 1'b0;
                        fault_nxt   = 1'b1;
                    end
                end
                LOCKOUT: begin
                    cnt_nxt = (cnt >= CNT_OFF_MAX) ? CNT_OFF_MAX : cnt + CNT_ONE;
                    // A stuck request must be seen low before the coil re-arms.
                    if ((cnt >= off_lim) && (release_seen || !req)) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt   = LOCKOUT;
                    cnt_nxt     = '0;
                    release_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= LOCKOUT;
            cnt          <= '0;
            release_seen <= 1'b0;
            fault        <= 1'b0;
            ign          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            release_seen <= release_nxt;
            fault        <= fault_nxt;
            ign          <= (state_nxt == CHARGE);
        end
    end

endmodule

// File: rtl/ign_output_stage.sv
// N-channel ignition output stage: maps per-cylinder dwell requests onto the
// physical coil outputs (individual / wasted-spark / distributor) and guards
// each coil against over-dwell and short off-times.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   synced          : decoder synced, low masks all requests
//   mode            : routing mode (efi_pkg MODE_*)
//   en              : per-logical-channel enable
//   coil_req        : per-channel dwell request, high = charge
//   max_dwell       : over-dwell limit in cycles, 0 disables
//   min_off         : minimum off-time after a coil turn-off, in cycles
//   clear_faults    : pulse clearing the sticky faults
//   ign_out         : coil drives, high = charging
//   fault_overdwell : sticky over-dwell flag per output
//   any_fault       : OR of fault_overdwell
module ign_output_stage
    import efi_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DWELL_W = 20,
    parameter int OFF_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               synced,
    input  logic [1:0]         mode,
    input  logic [N_CH-1:0]    en,
    input  logic [N_CH-1:0]    coil_req,
    input  logic [DWELL_W-1:0] max_dwell,
    input  logic [OFF_W-1:0]   min_off,
    input  logic               clear_faults,
    output logic [N_CH-1:0]    ign_out,
    output logic [N_CH-1:0]    fault_overdwell,
    output logic               any_fault
);

    localparam int HALF = N_CH / 2;

    logic [N_CH-1:0] q;
    logic [N_CH-1:0] r_map;
    logic [N_CH-1:0] r_reg;
    logic [1:0]      mode_q;
    logic            mode_chg;
    logic [N_CH-1:0] fault_nxt;

    assign q        = coil_req & en & {N_CH{synced}};
    assign mode_chg = (mode != mode_q);

    always_comb begin
        r_map = '0;
        case (mode)
            MODE_INDIV:  r_map = q;
            MODE_WASTED: begin
                for (int k = 0; k < HALF; k++) begin
                    r_map[k] = q[k] | q[k + HALF];
                end
            end
            MODE_DIST:   r_map[0] = |q;
            default:     r_map = '0;
        endcase
    end

    // The request pipeline keeps loading through reset so the guards see the
    // true request level on the first cycle after release; a request held
    // across reset therefore still needs a release before it can fire.
    always_ff @(posedge clk) begin
        r_reg  <= r_map;
        mode_q <= mode;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            any_fault <= 1'b0;
        end else begin
            any_fault <= |fault_nxt;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_guard
        ign_coil_guard #(
            .DWELL_W (DWELL_W),
            .OFF_W   (OFF_W)
        ) u_guard (
            .clk         (clk),
            .reset_n     (reset_n),
            .req         (r_reg[k]),
            .force_lock  (mode_chg),
            .max_dwell   (max_dwell),
            .min_off     (min_off),
            .clear_fault (clear_faults),
            .ign         (ign_out[k]),
            .fault       (fault_overdwell[k]),
            .fault_nxt   (fault_nxt[k])
        );
    end

endmodule

// File: tb/tb_ign_output_stage.sv
module tb_ign_output_stage;

    localparam int N_CH    = 4;
    localparam int DWELL_W = 20;
    localparam int OFF_W   = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               synced;
    logic [1:0]         mode;
    logic [N_CH-1:0]    en;
    logic [N_CH-1:0]    coil_req;
    logic [DWELL_W-1:0] max_dwell;
    logic [OFF_W-1:0]   min_off;
    logic               clear_faults;
    logic [N_CH-1:0]    ign_out;
    logic [N_CH-1:0]    fault_overdwell;
    logic               any_fault;

    int checks = 0;
    int errors = 0;
    int hi_cnt [N_CH];

    always #5 clk = ~clk;

    ign_output_stage #(
        .N_CH    (N_CH),
        .DWELL_W (DWELL_W),
        .OFF_W   (OFF_W)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .synced          (synced),
        .mode            (mode),
        .en              (en),
        .coil_req        (coil_req),
        .max_dwell       (max_dwell),
        .min_off         (min_off),
        .clear_faults    (clear_faults),
        .ign_out         (ign_out),
        .fault_overdwell (fault_overdwell),
        .any_fault       (any_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge and
    // accumulating the number of high cycles per output.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < N_CH; k++) hi_cnt[k] += int'(ign_out[k]);
        end
    endtask

    task automatic clr_hist();
        for (int k = 0; k < N_CH; k++) hi_cnt[k] = 0;
    endtask

    function automatic int hi_sum();
        int s = 0;
        for (int k = 0; k < N_CH; k++) s += hi_cnt[k];
        return s;
    endfunction

    initial begin
        reset_n      = 1'b0;
        synced       = 1'b1;
        mode         = 2'd0;
        en           = 4'hF;
        coil_req     = '0;
        max_dwell    = '0;
        min_off      = '0;
        clear_faults = 1'b0;
        clr_hist();

        // Reset state
        step(3);
        check("reset_ign", 32'(ign_out), 32'h0);
        check("reset_fault", 32'(fault_overdwell), 32'h0);
        check("reset_any", 32'(any_fault), 32'h0);
        reset_n = 1'b1;
        step(5);

        // Individual mode, 100-cycle pulse on channel 2
        clr_hist();
        coil_req = 4'b0100;
        step(1);
        check("lat_e1", 32'(ign_out[2]), 32'h0);
        step(1);
        check("lat_e2", 32'(ign_out[2]), 32'h1);
        step(98);
        coil_req = '0;
        step(10);
        check("pulse100_width", 32'(hi_cnt[2]), 32'd100);
        check("pulse100_others", 32'(hi_cnt[0] + hi_cnt[1] + hi_cnt[3]), 32'd0);
        check("pulse100_nofault", 32'(any_fault), 32'h0);

        // Over-dwell at 50 cycles, then re-fire after release and min_off
        max_dwell = 20'd50;
        min_off   = 16'd10;
        clr_hist();
        coil_req = 4'b0001;
        step(200);
        check("overdwell_width", 32'(hi_cnt[0]), 32'd50);
        check("overdwell_flag", 32'(fault_overdwell), 32'h1);
        check("overdwell_any", 32'(any_fault), 32'h1);
        coil_req = '0;
        step(20);
        clr_hist();
        coil_req = 4'b0001;
        step(30);
        coil_req = '0;
        step(15);
        check("refire_width", 32'(hi_cnt[0]), 32'd30);
        check("fault_sticky", 32'(fault_overdwell), 32'h1);
        clear_faults = 1'b1;
        step(1);
        clear_faults = 1'b0;
        check("clear_flag", 32'(fault_overdwell), 32'h0);
        check("clear_any", 32'(any_fault), 32'h0);

        // Wasted-spark: channel 3 pairs onto output 1
        max_dwell = '0;
        mode = 2'd1;
        step(30);
        clr_hist();
        coil_req = 4'b1000;
        step(20);
        coil_req = '0;
        step(15);
        check("wasted_out1", 32'(hi_cnt[1]), 32'd20);
        check("wasted_out3", 32'(hi_cnt[3]), 32'd0);
        check("wasted_other", 32'(hi_cnt[0] + hi_cnt[2]), 32'd0);

        // Distributor: everything onto output 0
        mode = 2'd2;
        step(30);
        clr_hist();
        coil_req = 4'b0100;
        step(15);
        coil_req = '0;
        step(15);
        check("dist_out0", 32'(hi_cnt[0]), 32'd15);
        check("dist_other", 32'(hi_cnt[1] + hi_cnt[2] + hi_cnt[3]), 32'd0);

        // Minimum off-time of 20 after a 10-cycle pulse, re-request after 5
        mode    = 2'd0;
        min_off = 16'd20;
        step(30);
        clr_hist();
        coil_req = 4'b0001;
        step(10);
        coil_req = '0;
        step(5);
        coil_req = 4'b0001;
        step(16);
        check("minoff_lock_end", 32'(ign_out[0]), 32'h0);
        step(1);
        check("minoff_idle", 32'(ign_out[0]), 32'h0);
        step(1);
        check("minoff_recharge", 32'(ign_out[0]), 32'h1);
        step(22);
        coil_req = '0;
        step(10);
        check("minoff_total", 32'(hi_cnt[0]), 32'd34);

        // Mid-charge mode change 0 -> 2
        step(30);
        coil_req = 4'b0010;
        step(10);
        check("modechg_before", 32'(ign_out[1]), 32'h1);
        mode = 2'd2;
        step(1);
        check("modechg_drop", 32'(ign_out), 32'h0);
        clr_hist();
        step(40);
        check("modechg_stuck", 32'(hi_sum()), 32'd0);
        coil_req = '0;
        step(30);
        coil_req = 4'b0010;
        step(5);
        check("modechg_refire", 32'(ign_out), 32'h1);
        coil_req = '0;
        step(30);

        // Set and clear in the same cycle: set wins
        mode      = 2'd0;
        max_dwell = 20'd50;
        step(30);
        clr_hist();
        coil_req = 4'b0100;
        step(51);
        clear_faults = 1'b1;
        step(1);
        clear_faults = 1'b0;
        check("setwins_flag", 32'(fault_overdwell), 32'h4);
        check("setwins_any", 32'(any_fault), 32'h1);
        check("setwins_ign", 32'(ign_out[2]), 32'h0);
        coil_req = '0;
        step(30);
        check("setwins_width", 32'(hi_cnt[2]), 32'd50);
        clear_faults = 1'b1;
        step(1);
        clear_faults = 1'b0;
        max_dwell = '0;

        // Disabled channel 1 never fires in any routing mode
        en = 4'b1101;
        for (int m = 0; m < 3; m++) begin
            mode = 2'(m);
            step(30);
            clr_hist();
            coil_req = 4'b0010;
            step(10);
            coil_req = '0;
            step(10);
            check($sformatf("en_off_mode%0d", m), 32'(hi_sum()), 32'd0);
        end

        // Reset while charging, request held through reset
        en   = 4'hF;
        mode = 2'd0;
        step(30);
        coil_req = 4'b0001;
        step(5);
        check("rst_chg_before", 32'(ign_out[0]), 32'h1);
        reset_n = 1'b0;
        step(1);
        check("rst_chg_drop", 32'(ign_out), 32'h0);
        reset_n = 1'b1;
        step(30);
        check("rst_chg_held", 32'(ign_out[0]), 32'h0);
        coil_req = '0;
        step(25);
        coil_req = 4'b0001;
        step(3);
        check("rst_chg_refire", 32'(ign_out[0]), 32'h1);
        coil_req = '0;
        step(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
